opcode_sequencer: RTL and testbench



---
 rtl/opcode_sequencer.sv | 86 ++++++++
 tb/tb_opcode_sequencer.sv | 118 +++++++++++
 2 files changed

// File: rtl/opcode_sequencer.sv
// opcode_sequencer: expands CALL/RET/RTI/interrupt into two micro-opcodes, inserts load-use bubbles and squashes flushed slots
module opcode_sequencer #(
  parameter logic [4:0] NOP_OP = 5'b00000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] instrOpCode,
  input  logic       instrValid,
  input  logic       flush,
  input  logic       loadUseHazard,
  input  logic       interruptReq,
  output logic [4:0] opCode,
  output logic       makeMeBubble,
  output logic       fetchStall,
  output logic       intAck,
  output logic       busy
);
  localparam logic [2:0] RUN   = 3'd0;
  localparam logic [2:0] CALL2 = 3'd1;
  localparam logic [2:0] RET2  = 3'd2;
  localparam logic [2:0] RTI2  = 3'd3;
  localparam logic [2:0] INT2  = 3'd4;
  localparam logic [4:0] OP_CALL  = 5'b11000;
  localparam logic [4:0] OP_CALL2 = 5'b11001;
  localparam logic [4:0] OP_RET   = 5'b11010;
  localparam logic [4:0] OP_RET2  = 5'b11011;
  localparam logic [4:0] OP_RTI   = 5'b11100;
  localparam logic [4:0] OP_RTI2  = 5'b11101;
  localparam logic [4:0] OP_INT   = 5'b11110;
  localparam logic [4:0] OP_INT2  = 5'b11111;
  logic [2:0] state_q, state_d;
  logic       int_pending_q, int_pending_d;
  logic       internal_op;
  assign internal_op = (instrOpCode == OP_CALL2) || (instrOpCode == OP_RET2) ||
                       (instrOpCode == OP_RTI2) || (instrOpCode == OP_INT) ||
                       (instrOpCode == OP_INT2);
  // a new request in the acknowledge cycle re-arms the flag
  assign int_pending_d = interruptReq | (int_pending_q & ~intAck);
  always_comb begin
    state_d      = RUN;
    opCode       = NOP_OP;
    makeMeBubble = 1'b0;
    fetchStall   = 1'b0;
    intAck       = 1'b0;
    busy         = 1'b0;
    if (rst) begin
      opCode     = 5'b00000;
      fetchStall = 1'b1;
    end else if (state_q != RUN) begin
      busy       = 1'b1;
      opCode     = state_q == CALL2 ? OP_CALL2 :
                   state_q == RET2  ? OP_RET2  :
                   state_q == RTI2  ? OP_RTI2  : OP_INT2;
      fetchStall = state_q == INT2;
      intAck     = state_q == INT2;
    end else if (flush) begin
      opCode = NOP_OP;
    end else if (int_pending_q) begin
      opCode     = OP_INT;
      fetchStall = 1'b1;
      state_d    = INT2;
    end else if (loadUseHazard) begin
      makeMeBubble = 1'b1;
      opCode       = instrOpCode;
      fetchStall   = 1'b1;
    end else if (!instrValid || internal_op) begin
      opCode = NOP_OP;
    end else if (instrOpCode == OP_CALL || instrOpCode == OP_RET || instrOpCode == OP_RTI) begin
      opCode     = instrOpCode;
      fetchStall = 1'b1;
      state_d    = instrOpCode == OP_CALL ? CALL2 :
                   instrOpCode == OP_RET  ? RET2  : RTI2;
    end else begin
      opCode = instrOpCode;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      int_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      int_pending_q <= int_pending_d;
    end
  end
endmodule

// File: tb/tb_opcode_sequencer.sv
// tb_opcode_sequencer: directed plus random stimulus checked against a behavioural micro-op model
module tb_opcode_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] instrOpCode;
  logic       instrValid, flush, loadUseHazard, interruptReq;
  logic [4:0] opCode;
  logic       makeMeBubble, fetchStall, intAck, busy;
  int checks = 0;
  int errors = 0;
  // model: a pending second-half opcode (if any) and the pending interrupt flag
  bit       m_second = 0;
  bit [4:0] m_next_op = 0;
  bit       m_pend = 0;
  logic [4:0] specials [8] = '{5'b11000, 5'b11010, 5'b11100, 5'b11001,
                               5'b11011, 5'b11101, 5'b11110, 5'b11111};
  opcode_sequencer dut (
    .clk(clk), .rst(rst), .instrOpCode(instrOpCode), .instrValid(instrValid),
    .flush(flush), .loadUseHazard(loadUseHazard), .interruptReq(interruptReq),
    .opCode(opCode), .makeMeBubble(makeMeBubble), .fetchStall(fetchStall),
    .intAck(intAck), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, got, exp);
    end
  endtask
  task automatic step(input bit r, input logic [4:0] op, input bit v, input bit f,
                      input bit h, input bit q);
    bit [4:0] e_op;
    bit e_bub, e_stall, e_ack, e_busy, n_second, n_pend;
    bit [4:0] n_next;
    rst = r; instrOpCode = op; instrValid = v; flush = f; loadUseHazard = h; interruptReq = q;
    #1;
    e_op = 5'b00000; e_bub = 0; e_stall = 0; e_ack = 0; e_busy = 0;
    n_second = 0; n_next = 0;
    if (r) begin
      e_stall = 1;
    end else if (m_second) begin
      e_op = m_next_op; e_busy = 1;
      e_stall = (m_next_op == 5'b11111); e_ack = e_stall;
    end else if (f) begin
      e_op = 5'b00000;
    end else if (m_pend) begin
      e_op = 5'b11110; e_stall = 1; n_second = 1; n_next = 5'b11111;
    end else if (h) begin
      e_bub = 1; e_op = op; e_stall = 1;
    end else if (!v) begin
      e_op = 5'b00000;
    end else if (op inside {5'b11000, 5'b11010, 5'b11100}) begin
      e_op = op; e_stall = 1; n_second = 1; n_next = op + 5'd1;
    end else if (op inside {5'b11001, 5'b11011, 5'b11101, 5'b11110, 5'b11111}) begin
      e_op = 5'b00000;
    end else begin
      e_op = op;
    end
    n_pend = r ? 1'b0 : (q || (m_pend && !e_ack));
    check("opCode", opCode, e_op);
    check("makeMeBubble", {4'b0, makeMeBubble}, {4'b0, e_bub});
    check("fetchStall", {4'b0, fetchStall}, {4'b0, e_stall});
    check("intAck", {4'b0, intAck}, {4'b0, e_ack});
    check("busy", {4'b0, busy}, {4'b0, e_busy});
    @(posedge clk);
    m_second = r ? 1'b0 : n_second;
    m_next_op = n_next;
    m_pend = n_pend;
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    step(1, 5'b01001, 1, 0, 0, 0);
    step(1, 5'b01001, 1, 0, 0, 0);
    step(0, 5'b01001, 1, 0, 0, 0);
    step(0, 5'b11000, 1, 0, 0, 0);
    step(0, 5'b01001, 1, 0, 0, 0);
    step(0, 5'b01001, 1, 0, 0, 0);
    step(0, 5'b11010, 1, 0, 0, 0);
    step(0, 5'b01001, 1, 0, 0, 0);
    step(0, 5'b01001, 1, 0, 0, 0);
    step(0, 5'b11100, 1, 0, 0, 0);
    step(0, 5'b01001, 1, 0, 0, 0);
    step(0, 5'b01001, 1, 0, 0, 0);
    step(0, 5'b01010, 1, 0, 0, 1);
    step(0, 5'b01010, 1, 0, 0, 0);
    step(0, 5'b01010, 1, 0, 0, 0);
    step(0, 5'b01010, 1, 0, 0, 0);
    step(0, 5'b01001, 1, 0, 1, 0);
    step(0, 5'b01001, 1, 0, 0, 0);
    step(0, 5'b01001, 1, 1, 1, 0);
    step(0, 5'b11000, 1, 0, 0, 0);
    step(0, 5'b11000, 1, 1, 1, 1);
    step(0, 5'b01001, 1, 0, 0, 0);
    step(0, 5'b01001, 1, 0, 0, 1);
    step(0, 5'b01001, 1, 0, 0, 0);
    step(0, 5'b01001, 1, 0, 0, 0);
    step(0, 5'b01001, 1, 0, 0, 0);
    step(0, 5'b11000, 1, 0, 0, 0);
    step(0, 5'b11000, 1, 0, 0, 0);
    step(0, 5'b11000, 1, 0, 0, 0);
    step(0, 5'b11000, 1, 0, 0, 0);
    step(0, 5'b11101, 1, 0, 0, 0);
    step(0, 5'b11010, 1, 0, 0, 0);
    step(1, 5'b01001, 1, 0, 0, 0);
    step(0, 5'b01001, 1, 0, 0, 0);
    step(0, 5'b01001, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 7)] : 5'($urandom);
      step($urandom_range(0, 59) == 0, op, $urandom_range(0, 7) != 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
